voice_scheduler: RTL and testbench

Time-multiplexes the single shared `wavetable` datapath across all synth voices once per audio sample period. On each `sample_tick` it sweeps the voice table, advancing each gated voice's phase accumulator and presenting phase, waveform and voice index to `wavetable`. After each lookup it captures the returned sample, sums the captured samples, and emits one saturated mixed sample to the output/DAC stage. It sits between the MIDI/config front end (per-voice writes) and the `wavetable` and output stage.

---
 rtl/synth_pkg.sv | 26 ++
 rtl/voice_state_bank.sv | 82 ++++++++
 rtl/voice_scheduler.sv | 176 +++++++++++++++++
 tb/tb_voice_scheduler.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared constants and types for the synth voice datapath: widths, the
// scheduler FSM encoding and the per-voice configuration record.
package synth_pkg;

    localparam int VOICE_IDX_W = 8;
    localparam int WT_PHASE_W  = 10;
    localparam int SAMPLE_W    = 16;
    localparam int WAVE_W      = 4;
    // Widest phase accumulator the config record can carry.
    localparam int INCR_MAX_W  = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACCUM,
        OUTPUT
    } sched_state_t;

    typedef struct packed {
        logic [INCR_MAX_W-1:0] incr;
        logic [WAVE_W-1:0]     wave;
        logic                  gate;
    } voice_cfg_t;

endpackage

// File: rtl/voice_state_bank.sv
// Per-voice registers: one config write port plus one combinational
// read / phase-advance port indexed by the scheduler's voice counter.
module voice_state_bank
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 16,
    parameter int PHASE_W    = 24,
    parameter int IDX_W      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_we,
    input  logic [VOICE_IDX_W-1:0] cfg_voice,
    input  voice_cfg_t             cfg_in,
    input  logic [IDX_W-1:0]       rd_idx,
    input  logic                   phase_adv,
    output logic [WAVE_W-1:0]      rd_wave,
    output logic                   rd_gate,
    output logic [WT_PHASE_W-1:0]  rd_phase_hi
);

    // Power-of-two depth keeps every index exactly IDX_W wide; entries at or
    // above NUM_VOICES are never written and stay at zero.
    localparam int DEPTH = 2 ** IDX_W;

    logic [PHASE_W-1:0] incr_q  [DEPTH];
    logic [PHASE_W-1:0] incr_d  [DEPTH];
    logic [WAVE_W-1:0]  wave_q  [DEPTH];
    logic [WAVE_W-1:0]  wave_d  [DEPTH];
    logic               gate_q  [DEPTH];
    logic               gate_d  [DEPTH];
    logic [PHASE_W-1:0] phase_q [DEPTH];
    logic [PHASE_W-1:0] phase_d [DEPTH];

    logic                  cfg_hit;
    logic [IDX_W-1:0]      cfg_idx;
    logic [INCR_MAX_W-1:0] unused_cfg_incr;

    assign cfg_hit         = cfg_we && (int'(cfg_voice) < NUM_VOICES);
    assign cfg_idx         = cfg_voice[IDX_W-1:0];
    assign unused_cfg_incr = cfg_in.incr;

    always_comb begin
        incr_d  = incr_q;
        wave_d  = wave_q;
        gate_d  = gate_q;
        phase_d = phase_q;
        if (phase_adv) begin
            phase_d[rd_idx] = phase_q[rd_idx] + incr_q[rd_idx];
        end
        // A voice being switched on restarts its waveform from phase zero.
        if (cfg_hit) begin
            incr_d[cfg_idx] = cfg_in.incr[PHASE_W-1:0];
            wave_d[cfg_idx] = cfg_in.wave;
            gate_d[cfg_idx] = cfg_in.gate;
            if (cfg_in.gate && !gate_q[cfg_idx]) begin
                phase_d[cfg_idx] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                incr_q[i]  <= '0;
                wave_q[i]  <= '0;
                gate_q[i]  <= 1'b0;
                phase_q[i] <= '0;
            end
        end else begin
            incr_q  <= incr_d;
            wave_q  <= wave_d;
            gate_q  <= gate_d;
            phase_q <= phase_d;
        end
    end

    assign rd_wave     = wave_q[rd_idx];
    assign rd_gate     = gate_q[rd_idx];
    assign rd_phase_hi = phase_q[rd_idx][PHASE_W-1 -: WT_PHASE_W];

endmodule

// File: rtl/voice_scheduler.sv
// Sweeps all voices through the shared wavetable once per sample tick and
// emits one saturated mix; mix_valid is a one-cycle strobe, no back-pressure.
module voice_scheduler
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 16,
    parameter int PHASE_W    = 24,
    parameter int WT_LATENCY = 3,
    parameter int MIX_SHIFT  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_tick,
    input  logic                       cfg_we,
    input  logic [VOICE_IDX_W-1:0]     cfg_voice,
    input  logic [PHASE_W-1:0]         cfg_incr,
    input  logic [WAVE_W-1:0]          cfg_wave,
    input  logic                       cfg_gate,
    output logic [WT_PHASE_W-1:0]      wt_phase,
    output logic [WAVE_W-1:0]          wt_wave_select,
    output logic [VOICE_IDX_W-1:0]     wt_voice_index,
    input  logic signed [SAMPLE_W-1:0] wt_sample,
    output logic signed [SAMPLE_W-1:0] mix_out,
    output logic                       mix_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W = 20;
    localparam int CNT_W = $clog2(WT_LATENCY);
    localparam logic [VOICE_IDX_W-1:0] LAST_V  = VOICE_IDX_W'(NUM_VOICES - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    sched_state_t               state_q, state_d;
    logic [VOICE_IDX_W-1:0]     v_q, v_d;
    logic [CNT_W-1:0]           wait_q, wait_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [WT_PHASE_W-1:0]      wt_phase_q, wt_phase_d;
    logic [WAVE_W-1:0]          wt_wave_q, wt_wave_d;
    logic [VOICE_IDX_W-1:0]     wt_voice_q, wt_voice_d;
    logic signed [SAMPLE_W-1:0] mix_out_q, mix_out_d;
    logic                       mix_valid_q, mix_valid_d;
    logic                       overrun_q, overrun_d;

    logic                       phase_adv;
    logic [WAVE_W-1:0]          rd_wave;
    logic                       rd_gate;
    logic [WT_PHASE_W-1:0]      rd_phase_hi;
    logic signed [ACC_W-1:0]    shifted;
    voice_cfg_t                 cfg_in;

    assign cfg_in = '{incr: INCR_MAX_W'(cfg_incr), wave: cfg_wave, gate: cfg_gate};

    voice_state_bank #(
        .NUM_VOICES (NUM_VOICES),
        .PHASE_W    (PHASE_W),
        .IDX_W      (IDX_W)
    ) u_bank (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_voice   (cfg_voice),
        .cfg_in      (cfg_in),
        .rd_idx      (v_q[IDX_W-1:0]),
        .phase_adv   (phase_adv),
        .rd_wave     (rd_wave),
        .rd_gate     (rd_gate),
        .rd_phase_hi (rd_phase_hi)
    );

    always_comb begin
        state_d     = state_q;
        v_d         = v_q;
        wait_d      = wait_q;
        acc_d       = acc_q;
        wt_phase_d  = wt_phase_q;
        wt_wave_d   = wt_wave_q;
        wt_voice_d  = wt_voice_q;
        mix_out_d   = mix_out_q;
        mix_valid_d = 1'b0;
        overrun_d   = sample_tick && (state_q != IDLE);
        phase_adv   = 1'b0;
        shifted     = acc_q >>> MIX_SHIFT;

        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    state_d = ISSUE;
                    v_d     = '0;
                    acc_d   = '0;
                end
            end
            ISSUE: begin
                if (rd_gate) begin
                    wt_phase_d = rd_phase_hi;
                    wt_wave_d  = rd_wave;
                    wt_voice_d = v_q;
                    phase_adv  = 1'b1;
                    wait_d     = CNT_W'(WT_LATENCY - 1);
                    state_d    = WAIT;
                end else if (v_q == LAST_V) begin
                    state_d = OUTPUT;
                end else begin
                    v_d = v_q + VOICE_IDX_W'(1);
                end
            end
            // wt_* are registers, so the wavetable sees the phase from the
            // first WAIT cycle; WT_LATENCY WAIT cycles put the capture in ACCUM.
            WAIT: begin
                if (wait_q == '0) begin
                    state_d = ACCUM;
                end else begin
                    wait_d = wait_q - CNT_W'(1);
                end
            end
            ACCUM: begin
                acc_d = acc_q + ACC_W'(wt_sample);
                if (v_q == LAST_V) begin
                    state_d = OUTPUT;
                end else begin
                    v_d     = v_q + VOICE_IDX_W'(1);
                    state_d = ISSUE;
                end
            end
            OUTPUT: begin
                if (shifted > SAT_MAX) begin
                    mix_out_d = 16'sh7FFF;
                end else if (shifted < SAT_MIN) begin
                    mix_out_d = 16'sh8000;
                end else begin
                    mix_out_d = shifted[SAMPLE_W-1:0];
                end
                mix_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            v_q         <= '0;
            wait_q      <= '0;
            acc_q       <= '0;
            wt_phase_q  <= '0;
            wt_wave_q   <= '0;
            wt_voice_q  <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            wait_q      <= wait_d;
            acc_q       <= acc_d;
            wt_phase_q  <= wt_phase_d;
            wt_wave_q   <= wt_wave_d;
            wt_voice_q  <= wt_voice_d;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign wt_phase       = wt_phase_q;
    assign wt_wave_select = wt_wave_q;
    assign wt_voice_index = wt_voice_q;
    assign mix_out        = mix_out_q;
    assign mix_valid      = mix_valid_q;
    assign overrun        = overrun_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: ticks push expected mixes into a queue,
// a negedge monitor pops and compares whenever mix_valid is seen.
module tb_voice_scheduler;

    typedef struct packed {
        logic [15:0] mix;
        logic [31:0] cyc;
        logic        chk_wt;
        logic [9:0]  phase;
        logic [3:0]  wave;
        logic [7:0]  vidx;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               sample_tick = 1'b0;
    logic               cfg_we = 1'b0;
    logic [7:0]         cfg_voice = '0;
    logic [23:0]        cfg_incr = '0;
    logic [3:0]         cfg_wave = '0;
    logic               cfg_gate = 1'b0;
    logic [9:0]         wt_phase;
    logic [3:0]         wt_wave_select;
    logic [7:0]         wt_voice_index;
    logic signed [15:0] wt_sample;
    logic signed [15:0] mix_out;
    logic               mix_valid;
    logic               busy;
    logic               overrun;

    logic signed [15:0] stub_const = '0;
    logic               stub_by_voice = 1'b0;

    exp_t        exp_q[$];
    logic [31:0] cyc = '0;
    logic [31:0] tick_edge = '0;
    int          n_vec = 0;
    int          n_err = 0;

    voice_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .sample_tick    (sample_tick),
        .cfg_we         (cfg_we),
        .cfg_voice      (cfg_voice),
        .cfg_incr       (cfg_incr),
        .cfg_wave       (cfg_wave),
        .cfg_gate       (cfg_gate),
        .wt_phase       (wt_phase),
        .wt_wave_select (wt_wave_select),
        .wt_voice_index (wt_voice_index),
        .wt_sample      (wt_sample),
        .mix_out        (mix_out),
        .mix_valid      (mix_valid),
        .busy           (busy),
        .overrun        (overrun)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Wavetable stand-in: a constant, or (voice+1)*100 per voice.
    always_comb begin
        if (stub_by_voice) wt_sample = 16'((int'(wt_voice_index) + 1) * 100);
        else               wt_sample = stub_const;
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero();
        check("rst_wt_phase", {22'd0, wt_phase}, 32'd0);
        check("rst_wt_wave", {28'd0, wt_wave_select}, 32'd0);
        check("rst_wt_voice", {24'd0, wt_voice_index}, 32'd0);
        check("rst_mix_out", {16'd0, mix_out}, 32'd0);
        check("rst_mix_valid", {31'd0, mix_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset && mix_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_mix_valid: got mix_out 0x%0h with nothing expected (cyc %0d)", mix_out, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("mix_out", {16'd0, mix_out}, {16'd0, e.mix});
                check("mix_valid_cycle", cyc, e.cyc);
                if (e.chk_wt) begin
                    check("wt_phase", {22'd0, wt_phase}, {22'd0, e.phase});
                    check("wt_wave_select", {28'd0, wt_wave_select}, {28'd0, e.wave});
                    check("wt_voice_index", {24'd0, wt_voice_index}, {24'd0, e.vidx});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cfg_write(input logic [7:0] v, input logic [23:0] incr,
                             input logic [3:0] wave, input logic gate);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_voice = v; cfg_incr = incr; cfg_wave = wave; cfg_gate = gate;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // lat = cycles from the tick's sampling edge to the mix_valid cycle
    task automatic do_tick(input logic push, input logic [15:0] mix, input int lat,
                           input logic chk, input logic [9:0] ph, input logic [3:0] wv,
                           input logic [7:0] vi);
        exp_t e;
        @(posedge clk); #1;
        sample_tick = 1'b1;
        tick_edge = cyc + 1;
        if (push) begin
            e = '{mix: mix, cyc: tick_edge + 32'(lat), chk_wt: chk, phase: ph, wave: wv, vidx: vi};
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        sample_tick = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d expected mixes never appeared", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic run_to(input logic [31:0] target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero();
        reset = 1'b0;

        // Out-of-range write must not alias onto voice 0; empty sweep timing + busy window
        cfg_write(8'd16, 24'h123456, 4'h5, 1'b1);
        @(posedge clk); #1;
        sample_tick = 1'b1;
        tick_edge = cyc + 1;
        exp_q.push_back('{mix: 16'h0000, cyc: tick_edge + 32'd17, chk_wt: 1'b1,
                          phase: 10'h0, wave: 4'h0, vidx: 8'h0});
        @(negedge clk);
        check("busy_cycle0", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        sample_tick = 1'b0;
        for (int r = 1; r <= 18; r++) begin
            @(negedge clk);
            check($sformatf("busy_cycle%0d", r), {31'd0, busy}, (r <= 17) ? 32'd1 : 32'd0);
        end
        wait_drain();

        // Single gated voice 3: top 10 bits of 0x040000 step by 0x010 per tick
        cfg_write(8'd3, 24'h040000, 4'h1, 1'b1);
        stub_const = 16'sd1000;
        do_tick(1'b1, 16'd250, 21, 1'b1, 10'h000, 4'h1, 8'd3); wait_drain();
        do_tick(1'b1, 16'd250, 21, 1'b1, 10'h010, 4'h1, 8'd3); wait_drain();
        do_tick(1'b1, 16'd250, 21, 1'b1, 10'h020, 4'h1, 8'd3); wait_drain();
        do_tick(1'b1, 16'd250, 21, 1'b1, 10'h030, 4'h1, 8'd3); wait_drain();

        // Phase wrap on voice 0 with incr 0xFFFFFF; -8 >>> 2 = -2
        cfg_write(8'd3, 24'h040000, 4'h1, 1'b0);
        cfg_write(8'd0, 24'hFFFFFF, 4'h2, 1'b1);
        stub_const = -16'sd8;
        do_tick(1'b1, 16'hFFFE, 21, 1'b1, 10'h000, 4'h2, 8'd0); wait_drain();
        do_tick(1'b1, 16'hFFFE, 21, 1'b1, 10'h3FF, 4'h2, 8'd0); wait_drain();
        do_tick(1'b1, 16'hFFFE, 21, 1'b1, 10'h3FF, 4'h2, 8'd0); wait_drain();

        // All 16 voices gated, voice v: incr v*0x1000, wave v
        for (int v = 0; v < 16; v++) begin
            cfg_write(8'(v), 24'(v * 24'h1000), 4'(v), 1'b1);
        end
        stub_const = 16'sh7FFF;
        do_tick(1'b1, 16'h7FFF, 81, 1'b1, 10'h000, 4'hF, 8'd15); wait_drain();
        stub_const = 16'sh8000;
        do_tick(1'b1, 16'h8000, 81, 1'b1, 10'h003, 4'hF, 8'd15); wait_drain();
        stub_by_voice = 1'b1;
        do_tick(1'b1, 16'd3400, 81, 1'b1, 10'h007, 4'hF, 8'd15); wait_drain();
        stub_by_voice = 1'b0;
        stub_const = -16'sd3;
        do_tick(1'b1, 16'hFFF4, 81, 1'b1, 10'h00B, 4'hF, 8'd15); wait_drain();

        // Tick during cycle 40 of a full sweep is dropped and flagged once
        stub_const = 16'sd100;
        do_tick(1'b1, 16'd400, 81, 1'b1, 10'h00F, 4'hF, 8'd15);
        run_to(tick_edge + 32'd39);
        sample_tick = 1'b1;
        @(negedge clk);
        check("overrun_cycle40", {31'd0, overrun}, 32'd0);
        @(posedge clk); #1;
        sample_tick = 1'b0;
        @(negedge clk);
        check("overrun_cycle41", {31'd0, overrun}, 32'd1);
        @(negedge clk);
        check("overrun_cycle42", {31'd0, overrun}, 32'd0);
        wait_drain();

        // Reset in cycle 30 aborts the sweep: no mix, outputs cleared at once
        do_tick(1'b0, 16'd0, 0, 1'b0, 10'h0, 4'h0, 8'd0);
        run_to(tick_edge + 32'd29);
        reset = 1'b1;
        #1;
        check_all_zero();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (100) @(posedge clk);

        // Fresh sweep after reset: every gate is back to 0
        stub_const = 16'sh7FFF;
        do_tick(1'b1, 16'h0000, 17, 1'b1, 10'h0, 4'h0, 8'd0); wait_drain();

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
